// File: rtl/dct_tp_pingpong.sv
// Ping-pong N x N coefficient buffer, emits each block row-major or transposed (mode latched per block).
// Registered output, first word 1 clk after block completes; in_ready drops when both banks full, out_valid/data_out hold while !out_ready.
module dct_tp_pingpong #(
    parameter int BW = 12,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] data_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          bypass,
    output logic [BW-1:0] data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          blk_done
);
    localparam int LN    = $clog2(N);
    localparam int AW    = 2 * LN;
    localparam int WORDS = N * N;
    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [BW-1:0] mem_q [0:2*WORDS-1];

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [BW-1:0] data_out_q, data_out_d;
    logic          out_valid_q, out_valid_d;
    logic          blk_done_q, blk_done_d;

    logic          wr_fire;
    logic          rd_fire;
    logic [AW-1:0] k_nxt;
    logic [AW-1:0] rd_addr;

    // Row-major index k = r*N + c; the transposed read address c*N + r is just the two fields swapped.
    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] k, input logic mode);
        return mode ? k : {k[LN-1:0], k[AW-1:LN]};
    endfunction

    assign in_ready  = rst | ~full_q[wr_bank_q];
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign blk_done  = blk_done_q;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid_q && out_ready;
    assign k_nxt   = k_q + 1'b1;
    assign rd_addr = map_addr(k_nxt, mode_q[rd_bank_q]);

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        mode_d      = mode_q;
        state_d     = state_q;
        k_d         = k_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        blk_done_d  = 1'b0;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == '0) begin
                mode_d[wr_bank_q] = bypass;
            end
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = STREAM;
                    k_d         = '0;
                    data_out_d  = mem_q[{rd_bank_q, {AW{1'b0}}}];
                    out_valid_d = 1'b1;
                end
            end
            STREAM: begin
                if (rd_fire) begin
                    if (k_q != LAST) begin
                        k_d        = k_nxt;
                        data_out_d = mem_q[{rd_bank_q, rd_addr}];
                    end else begin
                        blk_done_d        = 1'b1;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        k_d               = '0;
                        // Chain straight into the other bank when it is already waiting, so no bubble.
                        if (full_q[~rd_bank_q]) begin
                            data_out_d = mem_q[{~rd_bank_q, {AW{1'b0}}}];
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            mode_q      <= '0;
            state_q     <= IDLE;
            k_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            mode_q      <= mode_d;
            state_q     <= state_d;
            k_q         <= k_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            blk_done_q  <= blk_done_d;
        end
    end

    // Bank storage is not reset; full flags alone decide what is readable.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= data_in;
        end
    end

endmodule

// File: tb/tb_dct_tp_pingpong.sv
module tb_dct_tp_pingpong;
    localparam int BW    = 12;
    localparam int N     = 8;
    localparam int WORDS = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic          bypass;
    logic [BW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic          blk_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dct_tp_pingpong #(.BW(BW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bypass    (bypass),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_done  (blk_done)
    );

    typedef struct {
        bit            byp_start;  // bypass on word 0 of every block
        bit            byp_mid;    // bypass on the remaining words
        logic [BW-1:0] base;
        bit            exp_tp;     // expected: output transposed
        int            nblk;
        int            stall_k;    // output index held with out_ready=0
        int            stall_len;
        int            exp_drop;   // words accepted when in_ready first drops, -1 = never
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] exp_word(input vec_t v, input int j);
        int b;
        int e;
        int off;
        b   = j / WORDS;
        e   = j % WORDS;
        off = v.exp_tp ? (e % N) * N + e / N : e;
        return v.base + BW'(b * WORDS + off);
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int  tot;
        int  nin, nout, cyc, stall, gaps;
        int  last_in0, first_ov, drop, rise, acc63;
        bit  done_exp;
        tot = v.nblk * WORDS;
        nin = 0; nout = 0; cyc = 0; stall = 0; gaps = 0;
        last_in0 = -1; first_ov = -1; drop = -1; rise = -1; acc63 = -1;
        done_exp = 1'b0;
        while ((nin < tot || nout < tot) && cyc < 3000) begin
            chk($sformatf("v%0d blk_done", id), blk_done, done_exp);
            done_exp  = 1'b0;
            in_valid  = (nin < tot);
            data_in   = v.base + BW'(nin);
            bypass    = (nin % WORDS == 0) ? v.byp_start : v.byp_mid;
            out_ready = 1'b1;
            if (out_valid && nout == v.stall_k && stall < v.stall_len) begin
                out_ready = 1'b0;
                stall++;
                chk($sformatf("v%0d hold k=%0d", id, nout), data_out, exp_word(v, nout));
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (!out_valid && first_ov >= 0 && nout < tot) gaps++;
            if (in_valid && !in_ready && drop < 0) drop = nin;
            if (in_ready && drop >= 0 && rise < 0) rise = cyc;
            if (in_valid && in_ready) begin
                nin++;
                if (nin == WORDS) last_in0 = cyc;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("v%0d data j=%0d", id, nout), data_out, exp_word(v, nout));
                if (nout % WORDS == WORDS - 1) done_exp = 1'b1;
                if (nout == WORDS - 1) acc63 = cyc;
                nout++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL v%0d timeout: in=%0d out=%0d want %0d", id, nin, nout, tot);
        end
        chk($sformatf("v%0d final blk_done", id), blk_done, done_exp);
        chk($sformatf("v%0d idle out_valid", id), out_valid, 1'b0);
        chk($sformatf("v%0d latency", id), first_ov, last_in0 + 2);
        chk($sformatf("v%0d drop", id), drop, v.exp_drop);
        if (v.exp_drop < 0) chk($sformatf("v%0d gaps", id), gaps, 0);
        else                chk($sformatf("v%0d in_ready rise", id), rise, acc63 + 1);
        in_valid = 1'b0;
        tick();
        chk($sformatf("v%0d blk_done pulse", id), blk_done, 1'b0);
    endtask

    initial begin
        vec_t va;
        int   nin, nout, cyc;

        vecs[0] = '{1'b0, 1'b0, 12'h000, 1'b1, 1, 0, 0, -1};  // transpose
        vecs[1] = '{1'b1, 1'b1, 12'h000, 1'b0, 1, 0, 0, -1};  // bypass
        vecs[2] = '{1'b1, 1'b0, 12'h040, 1'b0, 1, 0, 0, -1};  // bypass latched, toggled mid-block
        vecs[3] = '{1'b0, 1'b1, 12'hF00, 1'b1, 1, 0, 0, -1};  // transpose latched, toggled mid-block
        vecs[4] = '{1'b0, 1'b0, 12'h000, 1'b1, 1, 1, 5, -1};  // hold word 8 for 5 cycles
        vecs[5] = '{1'b0, 1'b0, 12'h800, 1'b1, 2, 0, 0, -1};  // back-to-back blocks
        vecs[6] = '{1'b0, 1'b0, 12'h000, 1'b1, 3, 0, 80, 128}; // both banks full

        rst = 1'b1; in_valid = 1'b0; data_in = '0; bypass = 1'b0; out_ready = 1'b0;
        #1;
        chk("in_ready during reset", in_ready, 1'b1);
        tick();
        tick();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset data_out", data_out, '0);
        chk("reset blk_done", blk_done, 1'b0);
        rst = 1'b0;
        tick();
        chk("post-reset in_ready", in_ready, 1'b1);
        chk("post-reset out_valid", out_valid, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset with one block partly drained and the next partly written.
        va = '{1'b0, 1'b0, 12'h100, 1'b1, 1, 0, 0, -1};
        nin = 0; nout = 0; cyc = 0;
        while ((nin < WORDS + 30 || nout < 10) && cyc < 500) begin
            in_valid  = (nin < WORDS + 30);
            data_in   = 12'h100 + BW'(nin);
            bypass    = 1'b0;
            out_ready = (nout < 10);
            if (in_valid && in_ready) nin++;
            if (out_valid && out_ready) begin
                chk($sformatf("rst-seq data j=%0d", nout), data_out, exp_word(va, nout));
                nout++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 500) begin
            total++;
            bad++;
            $display("FAIL rst-seq timeout: in=%0d out=%0d", nin, nout);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid reset out_valid", out_valid, 1'b0);
        chk("mid reset data_out", data_out, '0);
        chk("mid reset blk_done", blk_done, 1'b0);
        chk("mid reset in_ready", in_ready, 1'b1);
        tick();
        chk("mid reset stays idle", out_valid, 1'b0);
        run_vec(7, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dct_tp_pingpong.md
DCT_TP_PINGPONG -- requirements
Module: dct_tp_pingpong

Interface
REQ-001 SHALL have parameter BW, default 12, meaning coefficient width in bits.
REQ-002 SHALL have parameter N, default 8, meaning block edge length; legal values are 4, 8 and 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port data_in, input, BW bits: coefficient stream in row-major order.
REQ-006 SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept data_in this cycle.
REQ-008 SHALL have port bypass, input, 1 bit: 1 = emit row-major (no transpose); 0 = emit transposed.
REQ-009 SHALL have port data_out, output, BW bits: registered output coefficient.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts data_out this cycle.
REQ-012 SHALL have port blk_done, output, 1 bit: one-cycle pulse when the last word of a block is accepted downstream.

Function
REQ-013 SHALL contain two banks of N*N words of BW bits (ping-pong), each with a full flag and a latched mode bit.
REQ-014 Input transfer SHALL occur on an edge where in_valid && in_ready; the word goes to write bank address wr_cnt, and wr_cnt advances 0..N*N-1 then wraps to 0.
REQ-015 in_ready SHALL equal !full[wr_bank] (combinational); in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-016 bypass SHALL be sampled into the write bank's mode bit on the transfer with wr_cnt=0; later changes within the block SHALL have no effect on that block.
REQ-017 On the transfer with wr_cnt=N*N-1: full[wr_bank] SHALL be set and wr_bank SHALL toggle on the same edge.
REQ-018 Read FSM states SHALL be IDLE and STREAM; IDLE->STREAM when full[rd_bank]=1, loading element 0 into data_out and setting out_valid on that edge, so out_valid is first seen 1 clock after the edge that completed the block.
REQ-019 In STREAM with read index k (row r=k/N, col c=k%N), the read address SHALL be c*N+r when mode=0, or k when mode=1.
REQ-020 On out_valid && out_ready with k<N*N-1: k increments and data_out loads the next element on the same edge, giving one word per clock under continuous out_ready.
REQ-021 On out_valid && !out_ready: data_out and out_valid SHALL hold unchanged.
REQ-022 On acceptance of k=N*N-1:
- blk_done pulses for 1 cycle.
- full[rd_bank] clears and rd_bank toggles.
- If the other bank is already full, element 0 of that bank loads on the same edge and out_valid stays 1 (no bubble).
- Otherwise the FSM goes to IDLE with out_valid=0.
REQ-023 Simultaneous write-completion of one bank and read-release of the other on the same edge SHALL both take effect.
REQ-024 A read-release edge SHALL set in_ready=1 for the next cycle if the writer was stalled on that bank.
REQ-025 Data SHALL pass bit-exact: no rounding, sign change or width change.
REQ-026 Sustained throughput SHALL be 1 word/clock in each direction when out_ready=1 continuously.

Reset
REQ-027 With rst=1 at an edge, the block SHALL clear on that edge:
- wr_cnt, k, wr_bank and rd_bank to 0.
- Both full flags to 0.
- The FSM to IDLE.
- out_valid=0, data_out=0, blk_done=0.
REQ-028 During and after reset, in_ready SHALL be 1.
REQ-029 Reset mid-block SHALL discard all partially written and unread data; bank memory contents need not be cleared.

Verification
REQ-030 Scenario 1 (N=8, bypass=0, out_ready=1): input 0..63 -> output sequence 0,8,16,...,56,1,9,...,63; out_valid rises 1 clock after the last input; blk_done pulses with word 63.
REQ-031 Scenario 2 (bypass=1): input 0..63 -> output 0,1,...,63 unchanged; then toggle bypass mid-block 2 -> block 2 still uses its latched mode.
REQ-032 Scenario 3 (backpressure): out_ready=0 for 5 cycles after element 8 is presented -> data_out holds 8 throughout; sequence resumes with 16 and no word is lost or duplicated.
REQ-033 Scenario 4 (full stall): out_ready=0 while 3 blocks are offered -> in_ready drops after word 127; in_ready returns 1 the clock after block 1's last output is accepted.
REQ-034 Scenario 5 (back-to-back): 2 consecutive blocks with out_ready=1 -> 128 contiguous valid outputs with no out_valid gap at the block boundary.
REQ-035 Scenario 6 (reset mid-block): rst asserted after 30 words in and 10 words out -> out_valid=0 next cycle; the next block 0..63 emerges correctly transposed.
